// File: rtl/tagged_vec_mul_pipe.sv
// ---------------------------------------------------------------------------
// tagged_vec_mul_pipe
//
// Purpose
//   Scales a tagged 3-lane signed fixed-point direction by a per-lane (or
//   broadcast) signed fixed-point factor. Each lane product is formed at full
//   2*WIDTH precision, optionally rounded half-up at the Q_BITS cut, shifted
//   back to Q(WIDTH-Q_BITS).Q_BITS and either saturated or wrapped. The tag
//   travels with its data, so results come out in acceptance order.
//
//   The pipeline is STAGES registers deep and uses a single global enable
//   (enable = !out_valid || out_ready). When the output is stalled, every
//   stage holds. This keeps in_ready independent of in_valid and dir_in.
//
// TaggedDirection packing (dir_in and TD_out), MSB to LSB:
//   [TAG_SIZE+3*WIDTH-1 : 3*WIDTH]  tag
//   [3*WIDTH-1 : 2*WIDTH]           x
//   [2*WIDTH-1 : WIDTH]             y
//   [WIDTH-1 : 0]                   z
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input beat offered
//   in_ready   input beat accepted this cycle (== pipeline enable)
//   mode       0: x*tx, y*ty, z*tz   1: x*tx, y*tx, z*tx
//   dir_in     tagged direction in
//   tx/ty/tz   signed scale factors
//   out_valid  result presented
//   out_ready  consumer takes the result this cycle
//   TD_out     tag plus three scaled lanes
//   ovf        per-lane overflow (bit0=x, bit1=y, bit2=z)
//   occupancy  number of valid beats in flight
// ---------------------------------------------------------------------------

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

module tagged_vec_mul_pipe #(
  parameter int WIDTH    = `WIDTH,
  parameter int Q_BITS   = `Q_BITS,   // legal range 1..WIDTH-1
  parameter int TAG_SIZE = 48,
  parameter int STAGES   = 2,         // legal range 1..4
  parameter bit SAT_EN   = 1'b1,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               mode,
  input  logic [TAG_SIZE+3*WIDTH-1:0]        dir_in,
  input  logic signed [WIDTH-1:0]            tx,
  input  logic signed [WIDTH-1:0]            ty,
  input  logic signed [WIDTH-1:0]            tz,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [TAG_SIZE+3*WIDTH-1:0]        TD_out,
  output logic [2:0]                         ovf,
  output logic [$clog2(STAGES+1)-1:0]        occupancy
);

  localparam int TD_W  = TAG_SIZE + 3*WIDTH;
  localparam int PW    = 2*WIDTH;
  localparam int OCC_W = $clog2(STAGES+1);

  // Half an output LSB, expressed at product scale.
  localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] RND_ADD = ROUND_EN ? (ONE_P << (Q_BITS-1)) : '0;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  genvar gi;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic enable;
  logic accept;
  logic fire;

  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;
  assign accept   = in_valid && enable;
  assign fire     = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // Lane operand selection and full-precision multiply
  // -------------------------------------------------------------------------
  logic [TAG_SIZE-1:0]    in_tag;
  logic [WIDTH-1:0]       op_a [3];
  logic [WIDTH-1:0]       op_b [3];
  logic [PW-1:0]          prod_comb [3];
  logic [PW-1:0]          round_src [3];

  assign in_tag  = dir_in[TD_W-1 -: TAG_SIZE];
  assign op_b[0] = tx;
  assign op_b[1] = mode ? tx : ty;
  assign op_b[2] = mode ? tx : tz;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_mul
      logic [PW-1:0] a_ext;
      logic [PW-1:0] b_ext;

      // x occupies the highest lane slot, z the lowest.
      assign op_a[gi] = dir_in[(2-gi)*WIDTH +: WIDTH];

      // Explicit sign extension; the low PW bits of the unsigned product of
      // two sign-extended operands equal the signed product.
      assign a_ext         = {{WIDTH{op_a[gi][WIDTH-1]}}, op_a[gi]};
      assign b_ext         = {{WIDTH{op_b[gi][WIDTH-1]}}, op_b[gi]};
      assign prod_comb[gi] = a_ext * b_ext;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Stage control: valid, tag and mode move together under the global enable.
  // A bubble (in_valid=0 while enabled) enters stage 1 as an invalid slot.
  // -------------------------------------------------------------------------
  logic                valid_reg [1:STAGES];
  logic [TAG_SIZE-1:0] tag_reg   [1:STAGES];
  logic                mode_reg  [1:STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= STAGES; s++) begin
        valid_reg[s] <= 1'b0;
        tag_reg[s]   <= '0;
        mode_reg[s]  <= 1'b0;
      end
    end else if (enable) begin
      valid_reg[1] <= in_valid;
      tag_reg[1]   <= in_tag;
      mode_reg[1]  <= mode;
      for (int s = 2; s <= STAGES; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        tag_reg[s]   <= tag_reg[s-1];
        mode_reg[s]  <= mode_reg[s-1];
      end
    end
  end

  // Mode has already been applied at the multiplier; the copy that rides the
  // pipeline alongside the tag ends here.
  logic unused_mode;
  assign unused_mode = mode_reg[STAGES];

  // -------------------------------------------------------------------------
  // Product registers. Stage 1 captures the multiply; stages 2..STAGES-1 are
  // pure delay. With STAGES=1 the multiply feeds round/saturate directly and
  // both land in the single output register.
  // -------------------------------------------------------------------------
  generate
    if (STAGES == 1) begin : g_no_prod
      for (gi = 0; gi < 3; gi++) begin : g_lane
        assign round_src[gi] = prod_comb[gi];
      end
    end else begin : g_prod
      logic [PW-1:0] prod_reg [1:STAGES-1][3];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 1; s < STAGES; s++) begin
            for (int l = 0; l < 3; l++) begin
              prod_reg[s][l] <= '0;
            end
          end
        end else if (enable) begin
          for (int l = 0; l < 3; l++) begin
            prod_reg[1][l] <= prod_comb[l];
          end
          for (int s = 2; s < STAGES; s++) begin
            for (int l = 0; l < 3; l++) begin
              prod_reg[s][l] <= prod_reg[s-1][l];
            end
          end
        end
      end

      for (gi = 0; gi < 3; gi++) begin : g_lane
        assign round_src[gi] = prod_reg[STAGES-1][gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round / shift / overflow / saturate, feeding the last stage register.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] res_next [3];
  logic [2:0]       ovf_next;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_rnd
      logic [PW-1:0]    rounded;
      logic [PW-1:0]    shifted;
      logic             lane_ovf;
      logic [WIDTH-1:0] lane_res;

      always_comb begin
        rounded  = round_src[gi] + RND_ADD;
        shifted  = $unsigned($signed(rounded) >>> Q_BITS);
        // The shifted value fits in WIDTH signed bits exactly when every bit
        // from the sign position upward is a copy of the sign.
        lane_ovf = !((&shifted[PW-1:WIDTH-1]) || !(|shifted[PW-1:WIDTH-1]));
        // shifted[WIDTH-1:0] is bits [WIDTH+Q_BITS-1:Q_BITS] of rounded,
        // i.e. the wrapped result.
        lane_res = shifted[WIDTH-1:0];
        if (SAT_EN && lane_ovf) begin
          // The rounding addend cannot flip the sign of an overflowing
          // product, so the raw product sign picks the rail.
          lane_res = round_src[gi][PW-1] ? SMIN : SMAX;
        end
      end

      assign res_next[gi] = lane_res;
      assign ovf_next[gi] = lane_ovf;
    end
  endgenerate

  logic [WIDTH-1:0] res_reg [3];
  logic [2:0]       ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 3; l++) begin
        res_reg[l] <= '0;
      end
      ovf_reg <= '0;
    end else if (enable) begin
      for (int l = 0; l < 3; l++) begin
        res_reg[l] <= res_next[l];
      end
      ovf_reg <= ovf_next;
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy: +1 on accept only, -1 on fire only.
  // -------------------------------------------------------------------------
  logic [OCC_W-1:0] occ_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else begin
      case ({accept, fire})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = valid_reg[STAGES];
  assign TD_out    = {tag_reg[STAGES], res_reg[0], res_reg[1], res_reg[2]};
  assign ovf       = ovf_reg;
  assign occupancy = occ_reg;

endmodule

// File: tb/tb_tagged_vec_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_tagged_vec_mul_pipe
//
// Directed bench for tagged_vec_mul_pipe. Two instances share the stimulus:
// dut uses round-half-up + saturation, dut_alt uses truncation + wrap.
// Each test task drives its own stimulus and checks inline.
// ---------------------------------------------------------------------------
module tb_tagged_vec_mul_pipe;

  localparam int W   = 32;
  localparam int Q   = 16;
  localparam int TW  = 48;
  localparam int STG = 2;
  localparam int TDW = TW + 3*W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           mode = 1'b0;
  logic [TDW-1:0] dir_in = '0;
  logic [W-1:0]   tx = '0;
  logic [W-1:0]   ty = '0;
  logic [W-1:0]   tz = '0;
  logic           out_ready = 1'b0;

  logic           in_ready, out_valid;
  logic [TDW-1:0] td_out;
  logic [2:0]     ovf;
  logic [1:0]     occupancy;

  logic           in_ready_a, out_valid_a;
  logic [TDW-1:0] td_out_a;
  logic [2:0]     ovf_a;
  logic [1:0]     occupancy_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tagged_vec_mul_pipe #(
    .WIDTH(W), .Q_BITS(Q), .TAG_SIZE(TW), .STAGES(STG),
    .SAT_EN(1'b1), .ROUND_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .dir_in(dir_in), .tx(tx), .ty(ty), .tz(tz),
    .out_valid(out_valid), .out_ready(out_ready), .TD_out(td_out),
    .ovf(ovf), .occupancy(occupancy)
  );

  tagged_vec_mul_pipe #(
    .WIDTH(W), .Q_BITS(Q), .TAG_SIZE(TW), .STAGES(STG),
    .SAT_EN(1'b0), .ROUND_EN(1'b0)
  ) dut_alt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .mode(mode), .dir_in(dir_in), .tx(tx), .ty(ty), .tz(tz),
    .out_valid(out_valid_a), .out_ready(out_ready), .TD_out(td_out_a),
    .ovf(ovf_a), .occupancy(occupancy_a)
  );

  // Place one beat on the inputs (no waiting).
  task automatic set_beat(input logic [TW-1:0] tag, input logic m,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, input logic [W-1:0] txv,
                          input logic [W-1:0] tyv, input logic [W-1:0] tzv);
    dir_in = {tag, x, y, z};
    mode   = m;
    tx     = txv;
    ty     = tyv;
    tz     = tzv;
  endtask

  // Offer one beat for one cycle; returns at the negedge of the cycle after
  // acceptance with in_valid low.
  task automatic send_beat(input logic [TW-1:0] tag, input logic m,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] z, input logic [W-1:0] txv,
                           input logic [W-1:0] tyv, input logic [W-1:0] tzv);
    @(negedge clk);
    set_beat(tag, m, x, y, z, txv, tyv, tzv);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    total++; if (ovf !== 3'b000) begin bad++; $display("FAIL reset_ovf: got %b want 000", ovf); end
    total++; if (td_out !== '0) begin bad++; $display("FAIL reset_td_out: got %h want 0", td_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (td_out_a !== '0) begin bad++; $display("FAIL reset_td_out_alt: got %h want 0", td_out_a); end
    rst = 1'b0;
    out_ready = 1'b1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_per_axis();
    logic [TDW-1:0] want;
    want = {48'hABC, 32'h00030000, 32'hFFFF0000, 32'h00010000};
    out_ready = 1'b1;
    send_beat(48'hABC, 1'b0, 32'h00018000, 32'h00010000, 32'h00004000,
              32'h00020000, 32'hFFFF0000, 32'h00040000);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL per_axis_early: got out_valid=%b want 0 one cycle after accept", out_valid); end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL per_axis_latency: got out_valid=%b want 1", out_valid); end
    total++; if (td_out !== want) begin bad++; $display("FAIL per_axis_data: got %h want %h", td_out, want); end
    total++; if (ovf !== 3'b000) begin bad++; $display("FAIL per_axis_ovf: got %b want 000", ovf); end
    total++; if (td_out_a !== want) begin bad++; $display("FAIL per_axis_data_alt: got %h want %h", td_out_a, want); end
    $display("per_axis: tag=%h x=%h y=%h z=%h", td_out[TDW-1 -: TW], td_out[2*W +: W], td_out[W +: W], td_out[0 +: W]);
  endtask

  task automatic test_rounding();
    logic [TDW-1:0] want_r, want_t;
    want_r = {48'h0000_0000_0011, 32'h00000001, 32'h00000000, 32'h00000000};
    want_t = {48'h0000_0000_0011, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    send_beat(48'h11, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h0,
              32'h00008000, 32'h00008000, 32'h0);
    @(negedge clk); #1;
    total++; if (td_out !== want_r) begin bad++; $display("FAIL round_half_up: got %h want %h", td_out, want_r); end
    total++; if (td_out_a !== want_t) begin bad++; $display("FAIL round_truncate: got %h want %h", td_out_a, want_t); end
    total++; if (ovf !== 3'b000 || ovf_a !== 3'b000) begin bad++; $display("FAIL round_ovf: got %b/%b want 000/000", ovf, ovf_a); end
    $display("rounding: round x=%h y=%h trunc x=%h y=%h", td_out[2*W +: W], td_out[W +: W], td_out_a[2*W +: W], td_out_a[W +: W]);
  endtask

  task automatic test_saturation();
    logic [TDW-1:0] want_s, want_w;
    want_s = {48'h22, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    want_w = {48'h22, 32'hFFFE0000, 32'h00000000, 32'h00000000};
    send_beat(48'h22, 1'b0, 32'h7FFF0000, 32'h80000000, 32'h0,
              32'h00020000, 32'h00020000, 32'h0);
    @(negedge clk); #1;
    total++; if (td_out !== want_s) begin bad++; $display("FAIL sat_data: got %h want %h", td_out, want_s); end
    total++; if (ovf !== 3'b011) begin bad++; $display("FAIL sat_ovf: got %b want 011", ovf); end
    total++; if (td_out_a !== want_w) begin bad++; $display("FAIL wrap_data: got %h want %h", td_out_a, want_w); end
    total++; if (ovf_a !== 3'b011) begin bad++; $display("FAIL wrap_ovf: got %b want 011", ovf_a); end
    $display("saturation: sat x=%h y=%h ovf=%b", td_out[2*W +: W], td_out[W +: W], ovf);
  endtask

  task automatic test_broadcast();
    logic [TDW-1:0] want;
    want = {48'h33, 32'h00030000, 32'h00030000, 32'h00030000};
    send_beat(48'h33, 1'b1, 32'h00010000, 32'h00010000, 32'h00010000,
              32'h00030000, 32'h0, 32'h0);
    @(negedge clk); #1;
    total++; if (td_out !== want) begin bad++; $display("FAIL broadcast: got %h want %h", td_out, want); end
    $display("broadcast: x=%h y=%h z=%h", td_out[2*W +: W], td_out[W +: W], td_out[0 +: W]);
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    @(negedge clk);
    set_beat(48'h111, 1'b0, 32'h00010000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd1) begin bad++; $display("FAIL bubble_c1: got valid=%b occ=%0d want 0/1", out_valid, occupancy); end
    @(negedge clk);
    set_beat(48'h222, 1'b0, 32'h00020000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0);
    in_valid = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1 || td_out[TDW-1 -: TW] !== 48'h111 || td_out[2*W +: W] !== 32'h00010000) begin bad++; $display("FAIL bubble_first: got valid=%b tag=%h x=%h want 1/111/00010000", out_valid, td_out[TDW-1 -: TW], td_out[2*W +: W]); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd1) begin bad++; $display("FAIL bubble_gap: got valid=%b occ=%0d want 0/1", out_valid, occupancy); end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1 || td_out[TDW-1 -: TW] !== 48'h222 || td_out[2*W +: W] !== 32'h00020000) begin bad++; $display("FAIL bubble_second: got valid=%b tag=%h x=%h want 1/222/00020000", out_valid, td_out[TDW-1 -: TW], td_out[2*W +: W]); end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL bubble_drain: got valid=%b occ=%0d want 0/0", out_valid, occupancy); end
    $display("bubble: two beats separated by one idle slot");
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int occ_model = 0;
    int cyc = 0;
    logic acc, fire, stalled_prev, saw_full_swap;
    logic [TDW-1:0] td_prev;
    logic [TW-1:0]  tg;
    logic [W-1:0]   xv, exp_x;
    stalled_prev  = 1'b0;
    saw_full_swap = 1'b0;
    td_prev       = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 8) begin
        tg = 48'h100 + 48'(sent);
        xv = 32'((sent + 1) << 16);
        set_beat(tg, 1'b0, xv, 32'h0, 32'h0, 32'h00020000, 32'h0, 32'h0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      total++; if (in_ready !== !(out_valid && !out_ready)) begin bad++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, !(out_valid && !out_ready)); end
      total++; if (occupancy !== 2'(occ_model) || occ_model > STG) begin bad++; $display("FAIL bp_occupancy cyc%0d: got %0d want %0d", cyc, occupancy, occ_model); end
      if (stalled_prev) begin
        total++; if (out_valid !== 1'b1 || td_out !== td_prev) begin bad++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, td_out, td_prev); end
      end
      if (fire) begin
        exp_x = 32'((2 * (got + 1)) << 16);
        total++;
        if (td_out[TDW-1 -: TW] !== 48'h100 + 48'(got) || td_out[2*W +: W] !== exp_x || ovf !== 3'b000) begin
          bad++;
          $display("FAIL bp_beat%0d: got tag=%h x=%h ovf=%b want tag=%h x=%h ovf=000", got, td_out[TDW-1 -: TW], td_out[2*W +: W], ovf, 48'h100 + 48'(got), exp_x);
        end
        $display("back_to_back: beat %0d tag=%h x=%h at cyc %0d", got, td_out[TDW-1 -: TW], td_out[2*W +: W], cyc);
        got++;
      end
      if (acc && fire && occupancy == 2'(STG)) saw_full_swap = 1'b1;
      stalled_prev = out_valid && !out_ready;
      td_prev      = td_out;
      occ_model    = occ_model + int'(acc) - int'(fire);
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (got != 8) begin bad++; $display("FAIL bp_count: got %0d beats want 8", got); end
    total++; if (!saw_full_swap) begin bad++; $display("FAIL bp_full_swap: got 0 accept-while-full cycles want at least 1"); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    @(negedge clk);
    set_beat(48'hDEAD, 1'b0, 32'h00010000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    set_beat(48'hBEEF, 1'b0, 32'h00010000, 32'h0, 32'h0, 32'h00010000, 32'h0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (occupancy !== 2'(STG) || out_valid !== 1'b1) begin bad++; $display("FAIL mid_fill: got occ=%0d valid=%b want %0d/1", occupancy, out_valid, STG); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL mid_async_clear: got valid=%b occ=%0d want 0/0", out_valid, occupancy); end
    total++; if (in_ready !== 1'b1 || td_out !== '0 || ovf !== 3'b000) begin bad++; $display("FAIL mid_reset_outputs: got ready=%b td=%h ovf=%b want 1/0/000", in_ready, td_out, ovf); end
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_xfer_in_reset: got occ=%0d valid=%b want 0/0", occupancy, out_valid); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_stale_beat: got %0d valid cycles want 0", seen); end
    $display("reset_midflight: pipeline flushed");
  endtask

  initial begin
    test_reset();
    test_per_axis();
    test_rounding();
    test_saturation();
    test_broadcast();
    test_bubble();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
